// File: rtl/i2c_master.sv
// I2C master: single-byte write and single-byte random read.
// Define I2C_MASTER_CLOCK_STRETCH_EN to honour slave clock stretching.
module i2c_master #(
  parameter int CLK_DIV     = 4,
  parameter int DEV_ADDR_W  = 7,
  parameter int WORD_ADDR_W = 7
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   rw,
  input  logic [DEV_ADDR_W-1:0]  dev_addr,
  input  logic [WORD_ADDR_W-1:0] word_addr,
  input  logic [7:0]             wdata,
  output logic                   busy,
  output logic                   done,
  output logic                   ack_err,
  output logic [7:0]             rdata,
  output logic                   scl_o,
  output logic                   sda_oe,
  input  logic                   sda_i,
  input  logic                   scl_i
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_START  = 4'd1;
  localparam logic [3:0] ST_DEVW   = 4'd2;
  localparam logic [3:0] ST_ACK1   = 4'd3;
  localparam logic [3:0] ST_WADR   = 4'd4;
  localparam logic [3:0] ST_ACK2   = 4'd5;
  localparam logic [3:0] ST_WDAT   = 4'd6;
  localparam logic [3:0] ST_ACK3   = 4'd7;
  localparam logic [3:0] ST_RSTART = 4'd8;
  localparam logic [3:0] ST_DEVR   = 4'd9;
  localparam logic [3:0] ST_ACK4   = 4'd10;
  localparam logic [3:0] ST_RDAT   = 4'd11;
  localparam logic [3:0] ST_MNACK  = 4'd12;
  localparam logic [3:0] ST_STOP   = 4'd13;
  localparam logic [3:0] ST_DONE   = 4'd14;

  logic [3:0]             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [1:0]             phase_q, phase_d;
  logic [2:0]             bit_q, bit_d;
  logic                   rw_q, rw_d;
  logic [DEV_ADDR_W-1:0]  dev_q, dev_d;
  logic [WORD_ADDR_W-1:0] wadr_q, wadr_d;
  logic [7:0]             wdat_q, wdat_d;
  logic [7:0]             sh_q, sh_d;
  logic [7:0]             rdata_q, rdata_d;
  logic                   samp_q, samp_d;
  logic                   ack_err_q, ack_err_d;
  logic                   done_q, done_d;

  logic       hold;
  logic       tick;
  logic       mid;
  logic       is_byte;
  logic       is_ack;
  logic [7:0] tx_byte;

`ifdef I2C_MASTER_CLOCK_STRETCH_EN
  // A slave holding SCL low while we release it freezes the phase timer.
  assign hold = scl_o & ~scl_i;
`else
  logic unused_scl_i;
  assign unused_scl_i = scl_i;
  assign hold = 1'b0;
`endif

  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;
  assign ack_err = ack_err_q;
  assign rdata   = rdata_q;
  assign tick    = (cnt_q == CNT_MAX);
  assign mid     = (phase_q == 2'd1) || (phase_q == 2'd2);

  assign is_byte = (state_q == ST_DEVW) || (state_q == ST_WADR) ||
                   (state_q == ST_WDAT) || (state_q == ST_DEVR) ||
                   (state_q == ST_RDAT);
  assign is_ack  = (state_q == ST_ACK1) || (state_q == ST_ACK2) ||
                   (state_q == ST_ACK3) || (state_q == ST_ACK4);

  always_comb begin
    tx_byte = 8'h00;
    unique case (state_q)
      ST_DEVW: tx_byte = 8'({dev_q, 1'b0});
      ST_WADR: tx_byte = 8'(wadr_q);
      ST_WDAT: tx_byte = wdat_q;
      ST_DEVR: tx_byte = 8'({dev_q, 1'b1});
      default: tx_byte = 8'h00;
    endcase
  end

  always_comb begin
    scl_o  = 1'b1;
    sda_oe = 1'b0;
    unique case (state_q)
      ST_START: begin
        scl_o  = (phase_q != 2'd3);
        sda_oe = phase_q[1];
      end
      ST_RSTART: begin
        scl_o  = mid;
        sda_oe = phase_q[1];
      end
      ST_STOP: begin
        scl_o  = (phase_q != 2'd0);
        sda_oe = ~phase_q[1];
      end
      ST_DEVW, ST_WADR, ST_WDAT, ST_DEVR: begin
        scl_o  = mid;
        sda_oe = ~tx_byte[3'd7 - bit_q];
      end
      ST_ACK1, ST_ACK2, ST_ACK3, ST_ACK4,
      ST_RDAT, ST_MNACK: scl_o = mid;
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    rw_d      = rw_q;
    dev_d     = dev_q;
    wadr_d    = wadr_q;
    wdat_d    = wdat_q;
    sh_d      = sh_q;
    rdata_d   = rdata_q;
    samp_d    = samp_q;
    ack_err_d = ack_err_q;
    done_d    = 1'b0;
    if (state_q == ST_IDLE) begin
      cnt_d   = '0;
      phase_d = 2'd0;
      bit_d   = 3'd0;
      if (start) begin
        rw_d      = rw;
        dev_d     = dev_addr;
        wadr_d    = word_addr;
        wdat_d    = wdata;
        ack_err_d = 1'b0;
        state_d   = ST_START;
      end
    end else if (state_q == ST_DONE) begin
      done_d  = 1'b1;
      state_d = ST_IDLE;
    end else if (!hold) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
      if (tick) begin
        phase_d = phase_q + 2'd1;
        if (phase_q == 2'd2) begin
          samp_d = sda_i;
          if (state_q == ST_RDAT) sh_d = {sh_q[6:0], sda_i};
        end
        if (phase_q == 2'd3) begin
          bit_d = is_byte ? bit_q + 3'd1 : 3'd0;
          if (is_ack && samp_q) ack_err_d = 1'b1;
          unique case (state_q)
            ST_START:  state_d = ST_DEVW;
            ST_DEVW:   if (bit_q == 3'd7) state_d = ST_ACK1;
            ST_WADR:   if (bit_q == 3'd7) state_d = ST_ACK2;
            ST_WDAT:   if (bit_q == 3'd7) state_d = ST_ACK3;
            ST_DEVR:   if (bit_q == 3'd7) state_d = ST_ACK4;
            ST_RDAT: begin
              if (bit_q == 3'd7) begin
                state_d = ST_MNACK;
                rdata_d = sh_q;
              end
            end
            ST_ACK1:   state_d = samp_q ? ST_STOP : ST_WADR;
            ST_ACK2: begin
              if (samp_q)    state_d = ST_STOP;
              else if (rw_q) state_d = ST_RSTART;
              else           state_d = ST_WDAT;
            end
            ST_ACK3:   state_d = ST_STOP;
            ST_ACK4:   state_d = samp_q ? ST_STOP : ST_RDAT;
            ST_RSTART: state_d = ST_DEVR;
            ST_MNACK:  state_d = ST_STOP;
            ST_STOP:   state_d = ST_DONE;
            default:   state_d = ST_IDLE;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      phase_q   <= 2'd0;
      bit_q     <= 3'd0;
      rw_q      <= 1'b0;
      dev_q     <= '0;
      wadr_q    <= '0;
      wdat_q    <= 8'h00;
      sh_q      <= 8'h00;
      rdata_q   <= 8'h00;
      samp_q    <= 1'b0;
      ack_err_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      rw_q      <= rw_d;
      dev_q     <= dev_d;
      wadr_q    <= wadr_d;
      wdat_q    <= wdat_d;
      sh_q      <= sh_d;
      rdata_q   <= rdata_d;
      samp_q    <= samp_d;
      ack_err_q <= ack_err_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: doc/i2c_master.md
Name: i2c_master

Overview:
- Bus-side I2C master that drives SCL/SDA into the I2C SRAM slave. It issues single-byte writes and single-byte random reads.
- Sits directly upstream of the slave. It turns a one-cycle command from host logic into the full START / address / word-address / data / STOP bit sequence on the open-drain bus, then returns read data and ACK status.

Parameters:
- CLK_DIV, 4: system clocks per SCL quarter-period; legal range ≥2. One SCL bit period = 4*CLK_DIV clocks.
- DEV_ADDR_W, 7: device address width; fixed I2C 7-bit.
- WORD_ADDR_W, 7: memory word-address width; sent as one byte, zero-extended at the MSB.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  command strobe; accepted only when busy=0.
- rw  in  1  1 = read, 0 = write.
- dev_addr  in  7  target slave address (slave answers to 7'h01).
- word_addr  in  7  SRAM word address.
- wdata  in  8  write byte.
- busy  out  1  high from the cycle after accept until done.
- done  out  1  one-cycle pulse at end of transaction.
- ack_err  out  1  slave NACKed; valid with done, held until the next accept.
- rdata  out  8  read byte; valid with done when rw=1, held until the next read completes.
- scl_o  out  1  1 = release SCL (pulled high), 0 = drive low.
- sda_oe  out  1  1 = drive SDA low, 0 = release.
- sda_i  in  1  sampled SDA line.
- scl_i  in  1  sampled SCL line; used only with the optional feature.

Behaviour:
- Reset: scl_o=1, sda_oe=0, busy=0, done=0, ack_err=0, rdata=8'h00, FSM=IDLE. Reset mid-transaction releases both lines on the next clock; no STOP is generated.
- Accept: on start=1 in IDLE, latch rw, dev_addr, word_addr and wdata; clear ack_err. start while busy is ignored.
- Tick generator: counter 0..CLK_DIV-1, running only when busy. A tick occurs at CLK_DIV-1. Each bit has 4 phases P0..P3, advancing one phase per tick.
- Data bit: P0 SCL low and SDA set up; P1 and P2 SCL released; sample sda_i at the end of P2; P3 SCL low.
- START: P0/P1 SDA released with SCL high; P2 SDA low; P3 SCL low.
- RSTART: P0 SCL low with SDA released; P1 SCL high; P2 SDA low; P3 SCL low.
- STOP: P0 SCL low with SDA low; P1 SCL high; P2 SDA released; P3 idle.
- FSM: IDLE -> START -> DEVW(8 bits: dev_addr,0) -> ACK1 -> WADR(8 bits: 0,word_addr) -> ACK2.
  - Write path: ACK2 -> WDAT(8) -> ACK3 -> STOP -> DONE.
  - Read path: ACK2 -> RSTART -> DEVR(dev_addr,1) -> ACK4 -> RDAT(8, SDA released) -> MNACK(SDA released for 1 bit) -> STOP -> DONE.
  - DONE: done=1 for one cycle, busy=0, then IDLE.
- Bit order: MSB first. Bits are counted by a 3-bit counter that wraps 7 -> 0 into the ACK state.
- ACK states: master releases SDA; sampled sda_i=1 means NACK. On NACK: ack_err=1, skip to STOP, done still pulses, rdata unchanged.
- rdata: assembled by shift-in, committed on the RDAT->MNACK transition.
- Latency, accept to done: write 29 bit periods = 116*CLK_DIV clocks, plus 1 clock for accept and 1 for DONE. Read 39 bit periods = 156*CLK_DIV clocks, plus 2.
- While IDLE: scl_o=1, sda_oe=0 at all times.

Optional Feature:
- Macro I2C_MASTER_CLOCK_STRETCH_EN.
- Defined: in any phase where scl_o=1, the tick counter holds while scl_i=0. This honours slave clock stretching, and latency extends by the stretch duration.
- Undefined: scl_i is ignored and timing is strictly CLK_DIV-based.

Test Plan:
- CLK_DIV=4; write dev 7'h01, addr 7'h12, data 8'hA5 with slave ACKing -> bytes 8'h02, 8'h12, 8'hA5 on SDA; done at accept+466 clocks; ack_err=0.
- Read dev 7'h01, addr 7'h12, slave returns 8'h3C -> bytes 02, 12, RSTART, 03; rdata=8'h3C at done (accept+626 clocks); master NACKs the data byte.
- dev_addr 7'h05, SDA high during ACK1 -> ack_err=1, STOP follows immediately, done pulses, rdata unchanged.
- Pulse start while busy with different operands -> ignored; the bus sequence still matches the first command.
- Assert reset during WDAT bit 3 -> next clock scl_o=1, sda_oe=0, busy=0; no done pulse; a fresh start then completes normally.
- With I2C_MASTER_CLOCK_STRETCH_EN, hold scl_i=0 for 20 clocks during ACK2 P1 -> done delayed by exactly 20 clocks; without the macro, delay is 0.
